// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dm_arbiter.
// The arbiter takes the slave view; requesters and the memory sit on the master view.
interface dm_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the word-access data memory.
// Each transaction runs IDLE -> ACCESS (one memory cycle) -> RESP (one-cycle ack).
module dm_arbiter #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus
);

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_gnt;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;

  logic        w_any;
  logic        w_gnt;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_range_err;
  logic        w_in_access;

  // On a tie the port that was not served last wins.
  assign w_any       = bus.p0_req | bus.p1_req;
  assign w_gnt       = (bus.p0_req & bus.p1_req) ? ~r_last : bus.p1_req;
  assign w_we        = w_gnt ? bus.p1_we    : bus.p0_we;
  assign w_addr      = w_gnt ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata     = w_gnt ? bus.p1_wdata : bus.p0_wdata;
  assign w_range_err = (w_addr > LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_range_err;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack/err are registered here so they are clean Moore outputs of RESP.
          if (r_gnt) begin
            r_ack1 <= 1'b1;
            r_err1 <= r_err;
            if (r_err)      r_rdata1 <= '0;
            else if (!r_we) r_rdata1 <= bus.mem_rdata;
          end else begin
            r_ack0 <= 1'b1;
            r_err0 <= r_err;
            if (r_err)      r_rdata0 <= '0;
            else if (!r_we) r_rdata0 <= bus.mem_rdata;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset in ACCESS kills a write at once.
  assign w_in_access   = (r_state == ACCESS);
  assign bus.mem_write = w_in_access &  r_we & ~r_err;
  assign bus.mem_read  = w_in_access & ~r_we & ~r_err;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.p0_ack   = r_ack0;
  assign bus.p0_err   = r_err0;
  assign bus.p0_rdata = r_rdata0;
  assign bus.p1_ack   = r_ack1;
  assign bus.p1_err   = r_err1;
  assign bus.p1_rdata = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a big-endian 128-byte memory model on the memory port and
// a transaction-level reference model predicting acks, errors, read data and memory.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.DEPTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory attached to the arbiter (combinational read, write on rising edge).
  logic [7:0]  mem [0:127];
  bit          mem_loaded = 1'b0;
  logic [31:0] mem_rd;

  // Reference model state.
  logic [7:0]  ref_mem [0:127];
  logic [31:0] ref_rdata [2];
  bit          ref_last;

  int n_checks = 0;
  int n_fail   = 0;

  always_comb begin
    mem_rd = '0;
    if (bus.mem_addr <= 32'd124)
      mem_rd = {mem[bus.mem_addr[6:0]], mem[bus.mem_addr[6:0] + 7'd1],
                mem[bus.mem_addr[6:0] + 7'd2], mem[bus.mem_addr[6:0] + 7'd3]};
  end
  assign bus.mem_rdata = mem_rd;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (bus.mem_write && bus.mem_addr <= 32'd124) begin
      mem[bus.mem_addr[6:0]]         <= bus.mem_wdata[31:24];
      mem[bus.mem_addr[6:0] + 7'd1]  <= bus.mem_wdata[23:16];
      mem[bus.mem_addr[6:0] + 7'd2]  <= bus.mem_wdata[15:8];
      mem[bus.mem_addr[6:0] + 7'd3]  <= bus.mem_wdata[7:0];
    end
  end

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // One complete transaction as the specification describes its effect.
  function automatic void model_txn(input bit port, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, output bit err);
    int a;
    err = (addr > 32'd124);
    a   = int'(addr[6:0]);
    if (err) ref_rdata[port] = '0;
    else if (we) begin
      ref_mem[a]   = wdata[31:24];
      ref_mem[a+1] = wdata[23:16];
      ref_mem[a+2] = wdata[15:8];
      ref_mem[a+3] = wdata[7:0];
    end else ref_rdata[port] = ref_word(a);
    ref_last = port;
  endfunction

  function automatic void model_reset();
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_last     = 1'b1;
  endfunction

  // Drives one request per enabled port from an IDLE cycle and records what comes back.
  task automatic drive(input bit en0, input bit en1, input bit we0, input bit we1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       output int c0, output int c1, output bit e0, output bit e1,
                       output int n_wr, output int n_rd, output bit stuck);
    @(negedge clk);
    bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
    bus.p0_req = en0; bus.p1_req = en1;
    c0 = -1; c1 = -1; e0 = 1'b0; e1 = 1'b0; n_wr = 0; n_rd = 0; stuck = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.mem_write) n_wr++;
      if (bus.mem_read)  n_rd++;
      if (bus.p0_ack) begin
        if (c0 < 0) begin c0 = c; e0 = bus.p0_err; bus.p0_req = 1'b0; end
        else stuck = 1'b1;
      end
      if (bus.p1_ack) begin
        if (c1 < 0) begin c1 = c; e1 = bus.p1_err; bus.p1_req = 1'b0; end
        else stuck = 1'b1;
      end
      if ((!en0 || c0 > 0) && (!en1 || c1 > 0)) break;
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(posedge clk); #1;
    if (bus.p0_ack || bus.p1_ack) stuck = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.mem_write, bus.mem_read} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.mem_write, bus.mem_read});
    end
    n_checks++;
    if ({bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_wdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want zeros",
               bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_write_read();
    int c0, c1, nw, nr; bit e0, e1, st;
    drive(1, 0, 1, 0, 32'd8, 32'd0, 32'hDEADBEEF, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 1, 32'd8, 32'hDEADBEEF, e1);
    n_checks++;
    if (c0 !== 2 || nw !== 1 || nr !== 0 || e0 !== 1'b0 || st) begin
      n_fail++;
      $display("FAIL wr8: ack_cyc=%0d wr=%0d rd=%0d err=%b stuck=%b want 2 1 0 0 0", c0, nw, nr, e0, st);
    end
    drive(1, 0, 0, 0, 32'd8, 32'd0, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 0, 32'd8, 32'd0, e1);
    n_checks++;
    if (c0 !== 2 || e0 !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF || nr !== 1) begin
      n_fail++;
      $display("FAIL rd8: ack_cyc=%0d err=%b rdata=%h rd=%0d want 2 0 deadbeef 1", c0, e0, bus.p0_rdata, nr);
    end
  endtask

  task automatic test_tie();
    int c0, c1, nw, nr; bit e0, e1, st, me;
    // Make port 1 the last served so the tie sequence starts with port 0.
    drive(0, 1, 0, 0, 32'd0, 32'd16, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(1, 0, 32'd16, 32'd0, me);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a0, a1;
      a0 = 32'($urandom_range(0, 31)) << 2;
      a1 = 32'($urandom_range(0, 31)) << 2;
      drive(1, 1, 0, 0, a0, a1, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
      model_txn(0, 0, a0, 32'd0, me);
      model_txn(1, 0, a1, 32'd0, me);
      n_checks++;
      if (c0 !== 2 || c1 !== 5 || st) begin
        n_fail++;
        $display("FAIL tie%0d: p0_ack=%0d p1_ack=%0d stuck=%b want 2 5 0", k, c0, c1, st);
      end
      n_checks++;
      if (bus.p0_rdata !== ref_rdata[0] || bus.p1_rdata !== ref_rdata[1]) begin
        n_fail++;
        $display("FAIL tie%0d_data: got %h %h want %h %h", k, bus.p0_rdata, bus.p1_rdata,
                 ref_rdata[0], ref_rdata[1]);
      end
    end
  endtask

  task automatic test_range();
    int c0, c1, nw, nr; bit e0, e1, st, me;
    drive(1, 0, 0, 0, 32'd125, 32'd0, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 0, 32'd125, 32'd0, me);
    n_checks++;
    if (c0 !== 2 || e0 !== 1'b1 || nw !== 0 || nr !== 0 || bus.p0_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rd125: ack=%0d err=%b wr=%0d rd=%0d rdata=%h want 2 1 0 0 0", c0, e0, nw, nr, bus.p0_rdata);
    end
    drive(1, 0, 1, 0, 32'hFFFFFFFC, 32'd0, 32'h55AA55AA, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 1, 32'hFFFFFFFC, 32'h55AA55AA, me);
    n_checks++;
    if (c0 !== 2 || e0 !== 1'b1 || nw !== 0 || nr !== 0 || mem_word(124) !== ref_word(124)) begin
      n_fail++;
      $display("FAIL wr_fffffffc: ack=%0d err=%b wr=%0d rd=%0d m124=%h want 2 1 0 0 %h",
               c0, e0, nw, nr, mem_word(124), ref_word(124));
    end
  endtask

  task automatic test_boundary();
    int c0, c1, nw, nr; bit e0, e1, st, me;
    drive(1, 0, 1, 0, 32'd124, 32'd0, 32'h11223344, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 1, 32'd124, 32'h11223344, me);
    n_checks++;
    if (c0 !== 2 || e0 !== 1'b0 || nw !== 1) begin
      n_fail++;
      $display("FAIL wr124: ack=%0d err=%b wr=%0d want 2 0 1", c0, e0, nw);
    end
    drive(0, 1, 0, 0, 32'd0, 32'd124, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(1, 0, 32'd124, 32'd0, me);
    n_checks++;
    if (c1 !== 2 || e1 !== 1'b0 || bus.p1_rdata !== 32'h11223344 || bus.p0_rdata !== ref_rdata[0]) begin
      n_fail++;
      $display("FAIL rd124: ack=%0d err=%b p1=%h p0=%h want 2 0 11223344 %h",
               c1, e1, bus.p1_rdata, bus.p0_rdata, ref_rdata[0]);
    end
  endtask

  task automatic test_held_req();
    int acks, first, second; logic [31:0] rd; bit me;
    acks = 0; first = -1; second = -1; rd = '0;
    @(negedge clk);
    bus.p1_we = 1'b0; bus.p1_addr = 32'd4; bus.p1_wdata = 32'd0; bus.p1_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.p1_ack) begin
        acks++;
        if (first < 0) first = c; else second = c;
        rd = bus.p1_rdata;
      end
      if (c == 4) bus.p1_req = 1'b0;
    end
    model_txn(1, 0, 32'd4, 32'd0, me);
    model_txn(1, 0, 32'd4, 32'd0, me);
    n_checks++;
    if (acks !== 2 || first !== 2 || second !== 5 || rd !== ref_rdata[1]) begin
      n_fail++;
      $display("FAIL held_req: acks=%0d first=%0d second=%0d rdata=%h want 2 2 5 %h",
               acks, first, second, rd, ref_rdata[1]);
    end
  endtask

  task automatic test_reset_mid();
    int c0, c1, nw, nr; bit e0, e1, st, me; bit wr_seen;
    @(negedge clk);
    bus.p0_we = 1'b1; bus.p0_addr = 32'd0; bus.p0_wdata = 32'hCAFEF00D; bus.p0_req = 1'b1;
    @(posedge clk); #1;
    wr_seen = bus.mem_write;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_seen !== 1'b1 || bus.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_write: before=%b after=%b want 1 0", wr_seen, bus.mem_write);
    end
    bus.p0_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.p0_ack !== 1'b0 || mem_word(0) !== ref_word(0)) begin
      n_fail++;
      $display("FAIL rst_mid_commit: ack=%b m0=%h want 0 %h", bus.p0_ack, mem_word(0), ref_word(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, c0, c1, e0, e1, nw, nr, st);
    model_txn(0, 0, 32'd0, 32'd0, me);
    n_checks++;
    if (c0 !== 2 || e0 !== 1'b0 || bus.p0_rdata !== ref_rdata[0] || bus.p1_rdata !== ref_rdata[1]) begin
      n_fail++;
      $display("FAIL rst_mid_read: ack=%0d err=%b p0=%h p1=%h want 2 0 %h %h",
               c0, e0, bus.p0_rdata, bus.p1_rdata, ref_rdata[0], ref_rdata[1]);
    end
  endtask

  task automatic test_random();
    int c0, c1, nw, nr, bad; bit e0, e1, st, ee0, ee1;
    for (int k = 0; k < 40; k++) begin
      int mode; bit we0, we1, win; logic [31:0] a0, a1, d0, d1;
      int ec0, ec1, ew, er;
      mode = int'($urandom % 3);
      we0 = 1'($urandom); we1 = 1'($urandom);
      d0 = $urandom; d1 = $urandom;
      a0 = ($urandom % 8 == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
      a1 = ($urandom % 8 == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
      if ($urandom % 2 == 0) a0 = a0 & ~32'd3;
      if ($urandom % 2 == 0) a1 = a1 & ~32'd3;
      ee0 = 1'b0; ee1 = 1'b0; ec0 = -1; ec1 = -1;
      drive(mode != 1, mode != 0, we0, we1, a0, a1, d0, d1, c0, c1, e0, e1, nw, nr, st);
      if (mode == 2) begin
        win = !ref_last;
        if (win) begin model_txn(1, we1, a1, d1, ee1); model_txn(0, we0, a0, d0, ee0); ec1 = 2; ec0 = 5; end
        else     begin model_txn(0, we0, a0, d0, ee0); model_txn(1, we1, a1, d1, ee1); ec0 = 2; ec1 = 5; end
      end else if (mode == 0) begin model_txn(0, we0, a0, d0, ee0); ec0 = 2; end
      else begin model_txn(1, we1, a1, d1, ee1); ec1 = 2; end
      ew = ((mode != 1 && we0 && !ee0) ? 1 : 0) + ((mode != 0 && we1 && !ee1) ? 1 : 0);
      er = ((mode != 1 && !we0 && !ee0) ? 1 : 0) + ((mode != 0 && !we1 && !ee1) ? 1 : 0);
      n_checks++;
      if (c0 !== ec0 || c1 !== ec1 || e0 !== ee0 || e1 !== ee1 || nw !== ew || nr !== er || st ||
          bus.p0_rdata !== ref_rdata[0] || bus.p1_rdata !== ref_rdata[1]) begin
        n_fail++;
        $display("FAIL rand%0d mode%0d: ack=%0d/%0d err=%b%b wr=%0d rd=%0d st=%b rd=%h/%h want %0d/%0d %b%b %0d %0d 0 %h/%h",
                 k, mode, c0, c1, e0, e1, nw, nr, st, bus.p0_rdata, bus.p1_rdata,
                 ec0, ec1, ee0, ee1, ew, er, ref_rdata[0], ref_rdata[1]);
      end
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mem_image: %0d differing bytes want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
    model_reset();
    rst_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_write_read();
    test_tie();
    test_range();
    test_boundary();
    test_held_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
